// File: rtl/toggle_event_encoder_pkg.sv
// toggle_event_encoder_pkg: shared state encoding and width helpers for the toggle event encoder.
package toggle_event_encoder_pkg;
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Hold counter width; a single-cycle hold still needs one bit.
    function automatic int hold_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction
endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: up/down counter that saturates at all-ones and floors at zero.
module sat_updown_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         drop_on_full
);
    logic full, empty;
    assign full = &count;
    assign empty = count == '0;
    assign drop_on_full = inc && !dec && full;
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (inc && !dec && !full) count <= count + 1'b1;
        else if (dec && !inc && !empty) count <= count - 1'b1;
endmodule

// File: rtl/toggle_event_encoder.sv
// toggle_event_encoder: turns event pulses into rate-limited flips of a single toggle line,
// queueing bursts in a saturating pending counter.
module toggle_event_encoder
    import toggle_event_encoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             clr_ovf,
    output logic             level,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);
    localparam int HOLD_W = hold_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic ready, avail, fire, drop;

    assign ready = state == IDLE || hold_cnt == '0;
    assign avail = tick_in || pending != '0;
    assign fire = ready && avail;
    assign busy = state == HOLD || pending != '0;

    // A fire always consumes one event: the bypassed tick or a queued one.
    sat_updown_counter #(.W(CNT_W)) u_pending (
        .clk(clk),
        .reset(reset),
        .inc(tick_in),
        .dec(fire),
        .count(pending),
        .drop_on_full(drop)
    );

    always_comb begin
        state_n = state;
        hold_n = hold_cnt;
        if (fire) begin
            state_n = HOLD;
            hold_n = HOLD_LOAD;
        end else if (state == HOLD) begin
            if (hold_cnt != '0) hold_n = hold_cnt - 1'b1;
            else if (!avail) state_n = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            hold_cnt <= '0;
            level <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            hold_cnt <= hold_n;
            level <= level ^ fire;
            overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end
endmodule

// File: tb/tb_toggle_event_encoder.sv
// tb_toggle_event_encoder: directed checks on two encoder configurations plus a random
// loopback through a dual-edge receiver, with a scoreboard of accepted events.
module tb_toggle_event_encoder;
    logic clk = 1'b0, reset = 1'b1;
    logic tick = 1'b0, clr = 1'b0, tick2 = 1'b0, clr2 = 1'b0;
    logic level, busy, overflow, level2, busy2, overflow2;
    logic [3:0] pending;
    logic [1:0] pending2;
    int checks = 0, fails = 0;
    int sb[$];

    always #5 clk = ~clk;

    toggle_event_encoder #(.HOLD_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .tick_in(tick), .clr_ovf(clr),
        .level(level), .busy(busy), .pending(pending), .overflow(overflow)
    );

    toggle_event_encoder #(.HOLD_CYCLES(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .tick_in(tick2), .clr_ovf(clr2),
        .level(level2), .busy(busy2), .pending(pending2), .overflow(overflow2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int flips, edges, pushed, since, exp_seq;
        logic prev;
        #2;
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_quiet", {level, busy, pending, overflow}, 0);
        end
        // single tick: flip after one edge, busy for four edges
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("single_level", level, 1);
        chk("single_pending", pending, 0);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("single_busy_hold", busy, 1);
        end
        step();
        chk("single_busy_end", busy, 0);
        chk("single_level_end", level, 1);
        // burst of three from a fresh reset
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        tick = 1'b1;
        step();
        chk("burst_flip1", level, 1);
        chk("burst_p1", pending, 0);
        step();
        chk("burst_p2", pending, 1);
        step();
        tick = 1'b0;
        chk("burst_p3", pending, 2);
        step();
        chk("burst_hold_level", level, 1);
        chk("burst_p4", pending, 2);
        step();
        chk("burst_flip2", level, 0);
        chk("burst_p5", pending, 1);
        for (int i = 6; i <= 8; i++) begin
            step();
            chk("burst_gap", level, 0);
        end
        step();
        chk("burst_flip3", level, 1);
        chk("burst_p9", pending, 0);
        for (int i = 0; i < 5; i++) step();
        chk("burst_idle", busy, 0);
        // overflow on the narrow, slow instance
        tick2 = 1'b1;
        step();
        chk("ovf_flip1", level2, 1);
        chk("ovf_p1", pending2, 0);
        step();
        chk("ovf_p2", pending2, 1);
        step();
        chk("ovf_p3", pending2, 2);
        step();
        chk("ovf_p4", pending2, 3);
        chk("ovf_not_yet", overflow2, 0);
        step();
        chk("ovf_set", overflow2, 1);
        chk("ovf_sat", pending2, 3);
        step();
        tick2 = 1'b0;
        chk("ovf_sat2", pending2, 3);
        flips = 1;
        prev = level2;
        for (int i = 0; i < 30; i++) begin
            step();
            if (level2 !== prev) flips++;
            prev = level2;
        end
        chk("ovf_flips", flips, 4);
        chk("ovf_drained", pending2, 0);
        chk("ovf_sticky", overflow2, 1);
        clr2 = 1'b1;
        step();
        clr2 = 1'b0;
        chk("ovf_clr", overflow2, 0);
        tick2 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("ovf_refill", pending2, 3);
        clr2 = 1'b1;
        step();
        tick2 = 1'b0;
        clr2 = 1'b0;
        chk("ovf_set_wins", overflow2, 1);
        // async reset mid-burst
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tick = 1'b0;
        chk("mid_pending", pending, 2);
        chk("mid_level", level, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_level", level, 0);
        chk("async_pending", pending, 0);
        chk("async_busy", busy, 0);
        chk("async_ovf2", overflow2, 0);
        reset = 1'b0;
        flips = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (level !== 1'b0 || pending !== 4'd0) flips++;
        end
        chk("post_reset_quiet", flips, 0);
        // random loopback: receiver ticks on every level change
        edges = 0;
        pushed = 0;
        since = 4;
        prev = level;
        for (int i = 0; i < 2200; i++) begin
            tick = (i < 2000) && ($urandom_range(5) == 0) && (pending < 4'd12);
            if (tick) sb.push_back(pushed++);
            step();
            tick = 1'b0;
            since++;
            if (level !== prev) begin
                chk("rx_spacing", int'(since >= 4), 1);
                if (sb.size() == 0) chk("rx_unexpected", edges, -1);
                else begin
                    exp_seq = sb.pop_front();
                    chk("rx_seq", edges, exp_seq);
                end
                edges++;
                since = 0;
            end
            prev = level;
        end
        chk("rx_queue_empty", sb.size(), 0);
        chk("rx_count", edges, pushed);
        chk("rx_no_overflow", overflow, 0);
        chk("rx_pending_zero", pending, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/toggle_event_encoder.md
Name: toggle_event_encoder

Overview:
Transmit end of toggle (dual-edge) event signalling: converts single-cycle event pulses into level transitions on one wire. Each accepted event flips `level` exactly once. Downstream, `dual_edge_detector_mealy` turns every flip back into one tick. Queues bursts in a saturating pending counter and enforces a minimum hold time between flips, so a slower or synchronised receiver never misses an edge.

Parameters:
HOLD_CYCLES, 4, minimum clock cycles between consecutive `level` flips; legal range >= 1.
CNT_W, 4, width of the pending-event counter; max queued events = 2^CNT_W-1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
tick_in  input  1  event request; each cycle sampled high = one event.
clr_ovf  input  1  synchronous clear of the `overflow` flag.
level  output  1  registered toggle line to the receiver.
busy  output  1  high while `state==HOLD` or `pending!=0`.
pending  output  CNT_W  events queued, not yet emitted.
overflow  output  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset (async, active-high; takes effect immediately, mid-burst included): `level`=0, `pending`=0, `overflow`=0, `state`=IDLE, `hold_cnt`=0. Queued events are discarded. `busy`=0.
- FSM states: IDLE (line quiet, may flip now) and HOLD (level recently flipped, hold timer running).
- `ready` = (state==IDLE) or (state==HOLD and hold_cnt==0).
- `avail` = tick_in or (pending!=0).
- `fire` = ready and avail.
- On `fire` at edge T:
  - `level` inverts.
  - `state` becomes HOLD.
  - `hold_cnt` loads HOLD_CYCLES-1.
- In HOLD without `fire`: if hold_cnt!=0, decrement it; if hold_cnt==0 and nothing is available, go to IDLE.
- Latency:
  - tick_in high in IDLE with pending==0: `level` flips at the very next edge (1 cycle). The event bypasses the counter.
  - Consecutive flips are exactly HOLD_CYCLES edges apart while events are queued.
  - HOLD_CYCLES=1 gives a flip on every edge.
- Pending update: pending_next = pending + tick_in - fire. "fire" here counts as consuming one event, either the bypassed tick or a queued one.
  - tick_in and fire in the same cycle: pending is unchanged.
  - pending==0, tick_in, fire: pending stays 0.
- Saturation: if pending==2^CNT_W-1 and tick_in and not fire, the event is dropped. pending holds, overflow sets.
  - If fire happens in that same cycle, there is no drop and no overflow.
- `overflow` stays set until a clr_ovf cycle. If a set and a clear occur in the same cycle, set wins.
- `level` is driven only from a flop. No combinational path from tick_in to level.
- `pending` wraps never: it saturates at max and floors at 0.
- Outputs are plain registers or simple decodes of registers. `busy` is derived combinationally from `state` and `pending` only.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=1'b0, HOLD=1'b1;
  - a clog2 helper;
  - HOLD_W = clog2(HOLD_CYCLES) (min 1), the width of the hold counter.
- One natural sub-module: `sat_updown_counter` (params W; inputs inc, dec; outputs count, drop_on_full). It is reused for `pending`.
- FSM, hold timer and level flop stay in the top.

Test Plan:
- Reset release, idle: no ticks for 20 cycles -> level=0, busy=0, pending=0, overflow=0 throughout.
- Single tick, HOLD_CYCLES=4, tick_in high at cycle C -> level flips 0->1 at edge C+1. busy is high through C+4, low from C+5. pending stays 0.
- Burst of 3 consecutive tick_in cycles, HOLD_CYCLES=4 -> flips at edges C+1, C+5, C+9. pending goes 1,2,2 after the burst edges, then 1 and 0 after the 2nd and 3rd flips. Final level=1.
- Overflow, CNT_W=2, HOLD_CYCLES=8, tick_in held 6 cycles -> pending saturates at 3. overflow=1 after the 5th tick (first tick fires, ticks 2-4 queue, tick 5 dropped). Exactly 4 flips occur in total. A single clr_ovf cycle then clears overflow. clr_ovf coinciding with a drop leaves overflow=1.
- Loopback into dual_edge_detector_mealy, random ticks for 2000 cycles with no overflow -> receiver tick count equals the count of accepted tick_in. Edge spacing is never below HOLD_CYCLES.
- Reset asserted mid-burst with pending=2 -> level, pending, busy and state clear immediately without waiting for clk. No further flips after release until a new tick_in.
